// File: rtl/i2s_tx_serializer_pkg.sv
// Shared types and constants for the I2S transmit serializer.
package i2s_tx_serializer_pkg;

    typedef enum logic [1:0] {WORD_16 = 2'd0, WORD_24 = 2'd1, WORD_32 = 2'd2} word_size_t;
    typedef enum logic       {FRAME_16 = 1'b0, FRAME_32 = 1'b1} frame_size_t;
    typedef enum logic [1:0] {STD_I2S = 2'd0, STD_MSB = 2'd1, STD_LSB = 2'd2} standard_t;
    typedef enum logic       {TX_IDLE = 1'b0, TX_RUN = 1'b1} tx_state_t;

    localparam int HF16 = 16;
    localparam int HF32 = 32;
    localparam int WL16 = 16;
    localparam int WL24 = 24;
    localparam int WL32 = 32;

    // Formatting fields captured at each frame start.
    typedef struct packed {
        word_size_t  word_size;
        frame_size_t frame_size;
        standard_t   standard;
        logic        mute;
        logic        stereo;
    } tx_cfg_t;

    function automatic logic [6:0] word_len(word_size_t w);
        case (w)
            WORD_16: return 7'(WL16);
            WORD_24: return 7'(WL24);
            default: return 7'(WL32);
        endcase
    endfunction

    function automatic logic [6:0] half_len(frame_size_t f);
        return (f == FRAME_32) ? 7'(HF32) : 7'(HF16);
    endfunction

endpackage

// File: rtl/i2s_tx_serializer_if.sv
// Sample-pair handshake between the sample source and the serializer.
interface i2s_tx_serializer_if #(parameter int DATA_W = 32);
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_left;
    logic [DATA_W-1:0] tx_right;

    modport master (output tx_valid, tx_left, tx_right, input tx_ready);
    modport slave  (input tx_valid, tx_left, tx_right, output tx_ready);
endinterface

// File: rtl/i2s_tx_serializer_shifter.sv
// Holds one half-word and maps a slot position inside the half to its data bit.
module i2s_tx_shifter
    import i2s_tx_serializer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] load_word,
    input  word_size_t  word_size,
    input  frame_size_t frame_size,
    input  standard_t   standard,
    input  logic [4:0]  pos,
    output logic        bit_o
);
    logic [31:0] word_q, word_d, cur_word;
    logic [6:0]  w_len, hf_len, w_eff, start, rel;
    logic [4:0]  idx;

    // Capture a new half-word on the tick that begins a half.
    always_comb begin
        word_d = word_q;
        if (en && load) word_d = load_word;
    end

    // Half-word storage.
    always_ff @(posedge clk) begin
        if (rst) word_q <= '0;
        else     word_q <= word_d;
    end

    // Slot-to-bit mapping; on a load tick the incoming word is used directly
    // because the output flop downstream captures this slot's bit now.
    always_comb begin
        cur_word = load ? load_word : word_q;
        w_len    = word_len(word_size);
        hf_len   = half_len(frame_size);
        w_eff    = (w_len < hf_len) ? w_len : hf_len;
        start    = (standard == STD_LSB) ? (hf_len - w_eff) : 7'd0;
        rel      = {2'b00, pos} - start;
        idx      = 5'(w_len - 7'd1 - rel);
        bit_o    = 1'b0;
        if (({2'b00, pos} >= start) && (rel < w_eff)) bit_o = cur_word[idx];
    end
endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S master-transmit serializer: holding register, frame FSM, WS/SD generation.
// Optional build macro TX_UNDERRUN_REPEAT_EN: on underrun, re-send the last pair.
module i2s_tx_serializer
    import i2s_tx_serializer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sck_fall_tick,
    input  word_size_t  cfg_word_size,
    input  frame_size_t cfg_frame_size,
    input  standard_t   cfg_standard,
    input  logic        cfg_mute,
    input  logic        cfg_stereo,
    input  logic        cfg_stop,
    i2s_tx_serializer_if.slave tx,
    output logic        ws,
    output logic        sd,
    output logic        busy,
    output logic        underrun
);
    tx_state_t         state_q, state_d;
    logic [5:0]        slot_q, slot_d, nslot, last_slot, hf_slot;
    tx_cfg_t           cfg_q, cfg_d, cfg_in, cfg_eff;
    logic              full_q, full_d;
    logic [DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [31:0]       rpend_q, rpend_d, left_src, right_src, sh_word;
    logic              ws_q, ws_d, sd_q, sd_d, dly_q, dly_d, underrun_q, underrun_d;
    logic              frame_start, stop_now, hf32_eff, sh_load, sh_bit;
    logic [4:0]        sh_pos;
`ifdef TX_UNDERRUN_REPEAT_EN
    logic [31:0]       last_l_q, last_l_d, last_r_q, last_r_d;
    logic              last_vld_q, last_vld_d;
`endif

    assign cfg_in = '{word_size: cfg_word_size, frame_size: cfg_frame_size,
                      standard: cfg_standard, mute: cfg_mute, stereo: cfg_stereo};

    // Frame sequencing, config latch and serial output next-state.
    always_comb begin
        state_d = state_q;  slot_d = slot_q;  cfg_d = cfg_q;  rpend_d = rpend_q;
        ws_d = ws_q;  sd_d = sd_q;  dly_d = dly_q;  underrun_d = 1'b0;
        frame_start = 1'b0;  stop_now = 1'b0;
        last_slot = (cfg_q.frame_size == FRAME_32) ? 6'd63 : 6'd31;
        if (sck_fall_tick) begin
            if (state_q == TX_IDLE) frame_start = !cfg_stop;
            else if (slot_q == last_slot) begin
                frame_start = !cfg_stop;
                stop_now    = cfg_stop;
            end
        end
        cfg_eff  = frame_start ? cfg_in : cfg_q;
        nslot    = frame_start ? 6'd0 : slot_q + 6'd1;
        hf32_eff = (cfg_eff.frame_size == FRAME_32);
        hf_slot  = hf32_eff ? 6'd32 : 6'd16;
        sh_pos   = hf32_eff ? nslot[4:0] : {1'b0, nslot[3:0]};

        // Empty holding register means zeros (or the previous pair when repeating).
        left_src = '0;  right_src = '0;
        if (full_q) begin
            left_src  = hold_l_q[31:0];
            right_src = hold_r_q[31:0];
        end
`ifdef TX_UNDERRUN_REPEAT_EN
        else if (last_vld_q) begin
            left_src  = last_l_q;
            right_src = last_r_q;
        end
`endif
        sh_load = frame_start ||
                  (sck_fall_tick && state_q == TX_RUN && !stop_now && nslot == hf_slot);
        sh_word = frame_start ? left_src : rpend_q;

        if (frame_start) begin
            state_d    = TX_RUN;
            cfg_d      = cfg_in;
            rpend_d    = cfg_eff.stereo ? right_src : left_src;
            underrun_d = !full_q;
        end
        if (frame_start || (sck_fall_tick && state_q == TX_RUN && !stop_now)) begin
            slot_d = nslot;
            ws_d   = hf32_eff ? nslot[5] : nslot[4];
            dly_d  = sh_bit;
            sd_d   = cfg_eff.mute ? 1'b0 : ((cfg_eff.standard == STD_I2S) ? dly_q : sh_bit);
        end else if (stop_now) begin
            state_d = TX_IDLE;  slot_d = '0;  ws_d = 1'b0;  sd_d = 1'b0;  dly_d = 1'b0;
        end
    end

    // Holding register: a new pair lands even when the frame start empties it.
    always_comb begin
        full_d = full_q;  hold_l_d = hold_l_q;  hold_r_d = hold_r_q;
        if (frame_start) full_d = 1'b0;
        if (tx.tx_valid && !full_q) begin
            full_d   = 1'b1;
            hold_l_d = tx.tx_left;
            hold_r_d = tx.tx_right;
        end
    end

`ifdef TX_UNDERRUN_REPEAT_EN
    // Remember the most recent real pair for underrun repetition.
    always_comb begin
        last_l_d = last_l_q;  last_r_d = last_r_q;  last_vld_d = last_vld_q;
        if (frame_start && full_q) begin
            last_l_d   = hold_l_q[31:0];
            last_r_d   = hold_r_q[31:0];
            last_vld_d = 1'b1;
        end
    end

    // Repeat-pair storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_l_q <= '0;  last_r_q <= '0;  last_vld_q <= 1'b0;
        end else begin
            last_l_q <= last_l_d;  last_r_q <= last_r_d;  last_vld_q <= last_vld_d;
        end
    end
`endif

    // All serializer state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TX_IDLE;  slot_q <= '0;  cfg_q <= '0;  rpend_q <= '0;
            full_q <= 1'b0;  hold_l_q <= '0;  hold_r_q <= '0;
            ws_q <= 1'b0;  sd_q <= 1'b0;  dly_q <= 1'b0;  underrun_q <= 1'b0;
        end else begin
            state_q <= state_d;  slot_q <= slot_d;  cfg_q <= cfg_d;  rpend_q <= rpend_d;
            full_q <= full_d;  hold_l_q <= hold_l_d;  hold_r_q <= hold_r_d;
            ws_q <= ws_d;  sd_q <= sd_d;  dly_q <= dly_d;  underrun_q <= underrun_d;
        end
    end

    i2s_tx_shifter u_shifter (
        .clk        (clk),
        .rst        (rst),
        .en         (sck_fall_tick),
        .load       (sh_load),
        .load_word  (sh_word),
        .word_size  (cfg_eff.word_size),
        .frame_size (cfg_eff.frame_size),
        .standard   (cfg_eff.standard),
        .pos        (sh_pos),
        .bit_o      (sh_bit)
    );

    assign tx.tx_ready = !full_q;
    assign ws          = ws_q;
    assign sd          = sd_q;
    assign busy        = (state_q == TX_RUN);
    assign underrun    = underrun_q;
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: vector table plus corner-case sequences.
module tb_i2s_tx_serializer;
    import i2s_tx_serializer_pkg::*;

    logic        clk = 1'b0, rst = 1'b1, tick = 1'b0;
    word_size_t  wsz = WORD_16;
    frame_size_t fsz = FRAME_16;
    standard_t   stdd = STD_MSB;
    logic        mute = 1'b0, stereo = 1'b1, stop = 1'b1;
    logic        ws, sd, busy, underrun;
    logic        s_ws, s_sd, s_busy, s_rdy, s_ur, s_ur2;
    int          checks = 0, passes = 0;

    i2s_tx_serializer_if #(.DATA_W(32)) tx_if ();

    i2s_tx_serializer #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .sck_fall_tick(tick),
        .cfg_word_size(wsz), .cfg_frame_size(fsz), .cfg_standard(stdd),
        .cfg_mute(mute), .cfg_stereo(stereo), .cfg_stop(stop),
        .tx(tx_if), .ws(ws), .sd(sd), .busy(busy), .underrun(underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        standard_t   st;
        word_size_t  w;
        frame_size_t f;
        logic        stereo;
        logic        mute;
        logic [31:0] l;
        logic [31:0] r;
        logic [63:0] exp_sd;   // slot k at bit 63-k
    } vec_t;
    vec_t vecs[10];

    localparam logic [63:0] WS16 = 64'h0000_FFFF_0000_0000;
    localparam logic [63:0] WS32 = 64'h0000_0000_FFFF_FFFF;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1; tick = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // One SCK falling-edge tick followed by one idle clk.
    task automatic do_tick();
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        s_ws = ws; s_sd = sd; s_busy = busy; s_rdy = tx_if.tx_ready; s_ur = underrun;
        @(posedge clk); #1;
        s_ur2 = underrun;
    endtask

    task automatic push(input logic [31:0] l, input logic [31:0] r);
        int n = 0;
        while (!tx_if.tx_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("push_ready", 64'(tx_if.tx_ready), 64'd1);
        tx_if.tx_valid = 1'b1; tx_if.tx_left = l; tx_if.tx_right = r;
        @(posedge clk); #1;
        tx_if.tx_valid = 1'b0;
    endtask

    task automatic run_frame(input int k0, input int kn, input int stop_at,
                             output logic [63:0] sd_s, output logic [63:0] ws_s,
                             output logic ur_first, output logic ur_later, output logic busy_last);
        sd_s = '0; ws_s = '0; ur_first = 1'b0; ur_later = 1'b0; busy_last = 1'b0;
        for (int k = k0; k < kn; k++) begin
            do_tick();
            sd_s[63-k] = s_sd;
            ws_s[63-k] = s_ws;
            if (k == k0) ur_first = s_ur;
            else         ur_later |= s_ur;
            ur_later |= s_ur2;
            busy_last = s_busy;
            if (k == stop_at) stop = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] gsd, gws, exp_rep;
        logic        urf, url, bl;
        int          nsl;

        vecs[0] = '{STD_MSB, WORD_16, FRAME_16, 1'b1, 1'b0, 32'h0000_A5F0, 32'h0000_0F0F, 64'hA5F0_0F0F_0000_0000};
        vecs[1] = '{STD_I2S, WORD_32, FRAME_32, 1'b1, 1'b0, 32'h8000_0001, 32'h0000_0000, 64'h4000_0000_8000_0000};
        vecs[2] = '{STD_LSB, WORD_16, FRAME_32, 1'b1, 1'b0, 32'hFFFF_A5F0, 32'h1234_0F0F, 64'h0000_A5F0_0000_0F0F};
        vecs[3] = '{STD_MSB, WORD_24, FRAME_16, 1'b1, 1'b0, 32'h00AB_CDEF, 32'h0012_3456, 64'hABCD_1234_0000_0000};
        vecs[4] = '{STD_MSB, WORD_16, FRAME_16, 1'b0, 1'b0, 32'h0000_C3A5, 32'h0000_FFFF, 64'hC3A5_C3A5_0000_0000};
        vecs[5] = '{STD_MSB, WORD_16, FRAME_16, 1'b1, 1'b1, 32'h0000_FFFF, 32'h0000_FFFF, 64'h0};
        vecs[6] = '{STD_LSB, WORD_24, FRAME_32, 1'b1, 1'b0, 32'h0012_3456, 32'h00FE_DCBA, 64'h0012_3456_00FE_DCBA};
        vecs[7] = '{STD_I2S, WORD_16, FRAME_16, 1'b1, 1'b0, 32'h0000_8001, 32'h0000_C000, 64'h4000_E000_0000_0000};
        vecs[8] = '{STD_I2S, WORD_32, FRAME_16, 1'b1, 1'b0, 32'hABCD_0000, 32'h1234_FFFF, 64'h55E6_891A_0000_0000};
        vecs[9] = '{STD_MSB, WORD_32, FRAME_32, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0123_4567, 64'hDEAD_BEEF_0123_4567};

        tx_if.tx_valid = 1'b0; tx_if.tx_left = '0; tx_if.tx_right = '0;
        do_reset();
        chk("reset_state", 64'({ws, sd, busy, underrun, tx_if.tx_ready}), 64'b00001);

        // Table: one frame per vector from IDLE, stop requested right after slot 0.
        for (int v = 0; v < 10; v++) begin
            do_reset();
            stdd = vecs[v].st; wsz = vecs[v].w; fsz = vecs[v].f;
            stereo = vecs[v].stereo; mute = vecs[v].mute;
            push(vecs[v].l, vecs[v].r);
            stop = 1'b0;
            nsl = (vecs[v].f == FRAME_32) ? 64 : 32;
            run_frame(0, nsl, 0, gsd, gws, urf, url, bl);
            chk($sformatf("vec%0d_sd", v), gsd, vecs[v].exp_sd);
            chk($sformatf("vec%0d_ws", v), gws, (vecs[v].f == FRAME_32) ? WS32 : WS16);
            chk($sformatf("vec%0d_underrun", v), 64'({urf, url}), 64'b00);
            do_tick();
            chk($sformatf("vec%0d_idle", v), 64'({s_busy, s_ws, s_sd}), 64'b000);
        end
        stdd = STD_MSB; wsz = WORD_16; fsz = FRAME_16; stereo = 1'b1; mute = 1'b0;

        // Handshake: ready drops after transfer, returns after the frame-start move.
        do_reset();
        push(32'h0000_1234, 32'h0000_5678);
        chk("ready_after_xfer", 64'(tx_if.tx_ready), 64'd0);
        stop = 1'b0;
        run_frame(0, 32, -1, gsd, gws, urf, url, bl);
        chk("ready_after_move", 64'(s_rdy), 64'd1);
        chk("frame1_sd", gsd, 64'h1234_5678_0000_0000);
        // Second frame starves; stop requested at slot 5.
        run_frame(0, 32, 5, gsd, gws, urf, url, bl);
        chk("underrun_pulse", 64'({urf, url}), 64'b10);
`ifdef TX_UNDERRUN_REPEAT_EN
        exp_rep = 64'h1234_5678_0000_0000;
`else
        exp_rep = 64'h0;
`endif
        chk("underrun_sd", gsd, exp_rep);
        chk("stop_busy_last_slot", 64'(bl), 64'd1);
        do_tick();
        chk("stop_idle", 64'({s_busy, s_ws, s_sd}), 64'b000);

        // Underrun straight after reset sends zeros in every build.
        do_reset();
        stop = 1'b0;
        run_frame(0, 32, 0, gsd, gws, urf, url, bl);
        chk("reset_underrun", 64'({urf, url}), 64'b10);
        chk("reset_underrun_sd", gsd, 64'h0);
        do_tick();

        // Mute: sd stays low while pairs keep flowing.
        do_reset();
        mute = 1'b1;
        push(32'h0000_FFFF, 32'h0000_FFFF);
        stop = 1'b0;
        do_tick();
        chk("mute_ready", 64'({s_rdy, s_sd, s_ur}), 64'b100);
        push(32'h0000_FFFF, 32'h0000_FFFF);
        run_frame(1, 32, -1, gsd, gws, urf, url, bl);
        chk("mute_sd1", gsd, 64'h0);
        run_frame(0, 32, 0, gsd, gws, urf, url, bl);
        chk("mute_sd2", gsd, 64'h0);
        chk("mute_no_underrun", 64'({urf, url}), 64'b00);
        do_tick();
        mute = 1'b0;

        // Reset mid-frame at slot 20 drops the queued pair.
        do_reset();
        push(32'h0000_FFFF, 32'h0000_FFFF);
        stop = 1'b0;
        run_frame(0, 21, -1, gsd, gws, urf, url, bl);
        chk("pre_reset_slot20", 64'({s_busy, s_ws, s_sd}), 64'b111);
        push(32'h0000_1111, 32'h0000_2222);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midframe_reset", 64'({ws, sd, busy, underrun, tx_if.tx_ready}), 64'b00001);
        rst = 1'b0;
        run_frame(0, 32, 0, gsd, gws, urf, url, bl);
        chk("pair_lost_underrun", 64'(urf), 64'd1);
        chk("pair_lost_sd", gsd, 64'h0);
        do_tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
